riscv_rf_wb_arb: RTL

RISCV_RF_WB_ARB -- requirements
Module: riscv_rf_wb_arb

---
 rtl/riscv_rf_wb_arb_pkg.sv | 15 +
 rtl/riscv_rf_wb_arb_if.sv | 27 ++
 rtl/riscv_rr_arbiter.sv | 33 +++
 rtl/riscv_rf_wb_arb.sv | 93 +++++++++
 4 files changed

// File: rtl/riscv_rf_wb_arb_pkg.sv
// rtl/riscv_rf_wb_arb_pkg.sv - shared register-index type, x0 constant and round-robin helper
package riscv_rf_wb_arb_pkg;

  localparam int AR_BITS_DEF = 5;

  typedef logic [AR_BITS_DEF-1:0] reg_idx_t;

  localparam reg_idx_t REG_X0 = '0;

  // Pointer successor after a grant to index g among n requesters.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/riscv_rf_wb_arb_if.sv
// rtl/riscv_rf_wb_arb_if.sv - writeback request/acknowledge bundle between requesters and arbiter
interface riscv_rf_wb_arb_if #(
  parameter int XLEN    = 32,
  parameter int AR_BITS = 5,
  parameter int NREQ    = 3
);

  logic [NREQ-1:0]    wb_req;
  logic [AR_BITS-1:0] wb_dst  [NREQ];
  logic [XLEN-1:0]    wb_dstv [NREQ];
  logic [NREQ-1:0]    wb_ack;

  modport master (
    output wb_req,
    output wb_dst,
    output wb_dstv,
    input  wb_ack
  );

  modport slave (
    input  wb_req,
    input  wb_dst,
    input  wb_dstv,
    output wb_ack
  );

endinterface

// File: rtl/riscv_rr_arbiter.sv
// rtl/riscv_rr_arbiter.sv - combinational round-robin grant starting at a pointer, wrapping modulo NREQ
module riscv_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  int            j;
  logic [PW-1:0] jj;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < NREQ; i++) begin
      j  = (int'(ptr_i) + i) % NREQ;
      jj = PW'(j);
      if (!valid_o && req_i[jj]) begin
        valid_o   = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/riscv_rf_wb_arb.sv
// rtl/riscv_rf_wb_arb.sv - register-file writeback arbiter with pending-write scoreboard
module riscv_rf_wb_arb
  import riscv_rf_wb_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AR_BITS = 5,
  parameter int NREQ    = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  riscv_rf_wb_arb_if.slave      wb,
  input  logic                  iss_valid,
  input  logic [AR_BITS-1:0]    iss_dst,
  input  logic                  du_stall,
  input  logic                  du_we_rf,
  output logic                  rf_we,
  output logic [AR_BITS-1:0]    rf_dst,
  output logic [XLEN-1:0]       rf_dstv,
  output logic [2**AR_BITS-1:0] sb_busy
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 2**AR_BITS;
  localparam logic [AR_BITS-1:0] X0 = AR_BITS'(REG_X0);

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               rf_we_q, rf_we_d;
  logic [AR_BITS-1:0] rf_dst_q, rf_dst_d;
  logic [XLEN-1:0]    rf_dstv_q, rf_dstv_d;
  logic [NREG-1:0]    busy_q, busy_d;

  logic               hold;
  logic [NREQ-1:0]    gnt;
  logic [PW-1:0]      gidx;
  logic               gvalid;
  logic [AR_BITS-1:0] g_dst;
  logic [XLEN-1:0]    g_dstv;
  logic               g_write;

  // Debug ownership, debug stall and reset all mask requests before arbitration.
  assign hold = du_we_rf | du_stall | ~rstn;

  riscv_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i   (wb.wb_req & {NREQ{~hold}}),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gidx),
    .valid_o (gvalid)
  );

  assign wb.wb_ack = gnt;
  assign g_dst     = wb.wb_dst[gidx];
  assign g_dstv    = wb.wb_dstv[gidx];
  assign g_write   = gvalid && (g_dst != X0);

  always_comb begin
    rr_ptr_d  = gvalid ? PW'(rr_next(int'(gidx), NREQ)) : rr_ptr_q;
    rf_we_d   = g_write;
    rf_dst_d  = g_write ? g_dst  : rf_dst_q;
    rf_dstv_d = g_write ? g_dstv : rf_dstv_q;
    busy_d    = busy_q;
    if (g_write) begin
      busy_d[g_dst] = 1'b0;
    end
    // Applied after the clear so an issue to the same register keeps it pending.
    if (iss_valid && (iss_dst != X0)) begin
      busy_d[iss_dst] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_dst_q  <= '0;
      rf_dstv_q <= '0;
      busy_q    <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rf_we_q   <= rf_we_d;
      rf_dst_q  <= rf_dst_d;
      rf_dstv_q <= rf_dstv_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_dst  = rf_dst_q;
  assign rf_dstv = rf_dstv_q;
  assign sb_busy = busy_q;

endmodule
